fpga_status_led: RTL and testbench

FPGA_STATUS_LED -- requirements
Module: fpga_status_led

---
 rtl/fpga_status_led.sv | 92 +++++++++
 tb/tb_fpga_status_led.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fpga_status_led.sv
// fpga_status_led: tick prescaler, heartbeat and program exit-code blinker driving per-LED modes
// Ports: clk_i/rst_i clock and async reset; mode_i 2-bit mode per LED (off/on/heartbeat/exit);
// exit_valid_i/exit_value_i program exit flag and value; led_o registered drives;
// tick_o prescaler strobe; exit_done_o value captured; exit_pass_o captured value was zero.
module fpga_status_led #(
  parameter int NUM_LEDS  = 4,
  parameter int TICK_DIV  = 12_500_000,
  parameter int GAP_TICKS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*NUM_LEDS-1:0] mode_i,
  input  logic                  exit_valid_i,
  input  logic [31:0]           exit_value_i,
  output logic [NUM_LEDS-1:0]   led_o,
  output logic                  tick_o,
  output logic                  exit_done_o,
  output logic                  exit_pass_o
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int GW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
  typedef enum logic [2:0] {IDLE, PASS, ON, OFF, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap, gap_n;
  logic [4:0] rem, rem_n;
  logic [31:0] val;
  logic valid_q, hb, capture, pattern;
  logic [NUM_LEDS-1:0] led_n;
  function automatic logic [4:0] burst_len(input logic [31:0] v);
    return v[3:0] == 4'd0 ? 5'd16 : {1'b0, v[3:0]};
  endfunction
  assign tick_o = cnt == TICK_LAST;
  // only the first edge after reset is honoured; exit_done_o doubles as the "already captured" flag
  assign capture = exit_valid_i & ~valid_q & ~exit_done_o;
  assign pattern = state == PASS || state == ON;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt         <= '0;
      hb          <= 1'b0;
      valid_q     <= 1'b0;
      val         <= '0;
      exit_done_o <= 1'b0;
      exit_pass_o <= 1'b0;
      state       <= IDLE;
      rem         <= '0;
      gap         <= '0;
      led_o       <= '0;
    end else begin
      cnt         <= tick_o ? '0 : cnt + 1'b1;
      hb          <= hb ^ tick_o;
      valid_q     <= exit_valid_i;
      val         <= capture ? exit_value_i : val;
      exit_done_o <= exit_done_o | capture;
      exit_pass_o <= capture ? exit_value_i == 32'd0 : exit_pass_o;
      state       <= state_n;
      rem         <= rem_n;
      gap         <= gap_n;
      led_o       <= led_n;
    end
  // a capture enters PASS/ON directly from IDLE, so a coincident tick is not consumed
  always_comb begin
    state_n = state;
    rem_n   = rem;
    gap_n   = gap;
    case (state)
      IDLE: if (capture) begin
        state_n = exit_value_i == 32'd0 ? PASS : ON;
        rem_n   = burst_len(exit_value_i);
      end
      ON: if (tick_o) state_n = OFF;
      OFF: if (tick_o) begin
        rem_n   = rem - 5'd1;
        state_n = rem == 5'd1 ? GAP : ON;
        gap_n   = '0;
      end
      GAP: if (tick_o) begin
        state_n = gap == GAP_LAST ? ON : GAP;
        rem_n   = gap == GAP_LAST ? burst_len(val) : rem;
        gap_n   = gap + 1'b1;
      end
      default: state_n = state;
    endcase
  end
  always_comb begin
    led_n = '0;
    for (int k = 0; k < NUM_LEDS; k++)
      led_n[k] = mode_i[2*k+1] ? (mode_i[2*k] ? pattern : hb) : mode_i[2*k];
  end
endmodule

// File: tb/tb_fpga_status_led.sv
// tb_fpga_status_led: directed self-checking bench for fpga_status_led (TICK_DIV=4, GAP_TICKS=2)
module tb_fpga_status_led;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] mode_i = '0;
  logic exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic [3:0] led_o;
  logic tick_o, exit_done_o, exit_pass_o;
  int pass_cnt = 0;
  int total = 0;
  fpga_status_led #(.NUM_LEDS(4), .TICK_DIV(4), .GAP_TICKS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .led_o(led_o), .tick_o(tick_o),
    .exit_done_o(exit_done_o), .exit_pass_o(exit_pass_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  // Hand-derived exit pattern for a capture whose first ON state spans cycles f..3 (0 <= f <= 3)
  // of the first tick window: each pulse is 1 tick ON + 1 tick OFF (8 cycles), then 2 gap ticks.
  function automatic logic exp_pat(input int m, input int p, input int f);
    int b, q;
    b = 8 * p + 8;
    if (m < 0) return 1'b0;
    if (m < b) return (m / 8 == 0) ? (m >= f && m <= 3) : (m / 8 < p && m % 8 < 4);
    q = (m - b) % b;
    return q / 8 < p && q % 8 < 4;
  endfunction
  task automatic do_reset(input logic v, input logic [31:0] value, input logic [7:0] mode);
    rst_i = 1'b1;
    exit_valid_i = v;
    exit_value_i = value;
    mode_i = mode;
    step;
    step;
    rst_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    mode_i = 8'hFF;
    step;
    total++; if (led_o !== 4'h0) $display("FAIL reset_led got %h want 0", led_o); else pass_cnt++;
    total++; if (tick_o !== 1'b0) $display("FAIL reset_tick got %b want 0", tick_o); else pass_cnt++;
    total++; if (exit_done_o !== 1'b0) $display("FAIL reset_done got %b want 0", exit_done_o); else pass_cnt++;
    total++; if (exit_pass_o !== 1'b0) $display("FAIL reset_pass got %b want 0", exit_pass_o); else pass_cnt++;
  endtask
  task automatic test_heartbeat;
    logic [3:0] e;
    do_reset(1'b0, 32'd0, 8'hAA);
    for (int n = 1; n <= 16; n++) begin
      step;
      e = ((n - 1) / 4) % 2 == 1 ? 4'hF : 4'h0;
      total++; if (tick_o !== (n % 4 == 3)) $display("FAIL hb_tick n=%0d got %b want %b", n, tick_o, n % 4 == 3); else pass_cnt++;
      total++; if (led_o !== e) $display("FAIL hb_led n=%0d got %h want %h", n, led_o, e); else pass_cnt++;
    end
  endtask
  task automatic test_exit_pass;
    do_reset(1'b0, 32'd0, 8'h03);
    step;
    step;
    total++; if (exit_done_o !== 1'b0) $display("FAIL pass_done_early got %b want 0", exit_done_o); else pass_cnt++;
    exit_valid_i = 1'b1;
    step;
    total++; if (exit_done_o !== 1'b1) $display("FAIL pass_done got %b want 1", exit_done_o); else pass_cnt++;
    total++; if (exit_pass_o !== 1'b1) $display("FAIL pass_pass got %b want 1", exit_pass_o); else pass_cnt++;
    total++; if (led_o !== 4'h0) $display("FAIL pass_led_lat got %h want 0", led_o); else pass_cnt++;
    step;
    total++; if (led_o !== 4'h1) $display("FAIL pass_led got %h want 1", led_o); else pass_cnt++;
    exit_valid_i = 1'b0;
    step;
    exit_valid_i = 1'b1;
    exit_value_i = 32'd5;
    for (int n = 0; n < 20; n++) begin
      step;
      total++; if (led_o !== 4'h1 || exit_pass_o !== 1'b1) $display("FAIL pass_hold n=%0d got led %h pass %b want 1 1", n, led_o, exit_pass_o); else pass_cnt++;
    end
  endtask
  task automatic test_burst(input logic [31:0] value, input int p, input int last);
    logic [3:0] e;
    do_reset(1'b0, value, 8'h03);
    step;
    step;
    exit_valid_i = 1'b1;
    for (int n = 3; n <= last; n++) begin
      step;
      if (n == 50) exit_valid_i = 1'b0;
      if (n == 55) begin
        exit_valid_i = 1'b1;
        exit_value_i = 32'd0;
      end
      e = {3'b000, exp_pat(n - 1, p, 3)};
      total++; if (led_o !== e) $display("FAIL burst%0d_led n=%0d got %h want %h", p, n, led_o, e); else pass_cnt++;
    end
    total++; if (exit_done_o !== 1'b1) $display("FAIL burst%0d_done got %b want 1", p, exit_done_o); else pass_cnt++;
    total++; if (exit_pass_o !== 1'b0) $display("FAIL burst%0d_pass got %b want 0", p, exit_pass_o); else pass_cnt++;
  endtask
  task automatic test_capture_on_tick;
    logic [3:0] e;
    do_reset(1'b0, 32'd2, 8'h03);
    step;
    step;
    step;
    total++; if (tick_o !== 1'b1) $display("FAIL cot_tick got %b want 1", tick_o); else pass_cnt++;
    exit_valid_i = 1'b1;
    for (int n = 4; n <= 70; n++) begin
      step;
      e = {3'b000, exp_pat(n - 5, 2, 0)};
      total++; if (led_o !== e) $display("FAIL cot_led n=%0d got %h want %h", n, led_o, e); else pass_cnt++;
    end
  endtask
  task automatic test_reset_restart;
    logic [3:0] e;
    logic p;
    do_reset(1'b0, 32'd3, 8'h03);
    step;
    step;
    exit_valid_i = 1'b1;
    for (int n = 3; n <= 10; n++) step;
    total++; if (led_o !== 4'h1) $display("FAIL rr_pulse2 got %h want 1", led_o); else pass_cnt++;
    rst_i = 1'b1;
    #1;
    total++; if (led_o !== 4'h0) $display("FAIL rr_async_led got %h want 0", led_o); else pass_cnt++;
    total++; if (exit_done_o !== 1'b0) $display("FAIL rr_async_done got %b want 0", exit_done_o); else pass_cnt++;
    step;
    step;
    rst_i = 1'b0;
    total++; if (exit_done_o !== 1'b0) $display("FAIL rr_done_rel got %b want 0", exit_done_o); else pass_cnt++;
    for (int n = 1; n <= 80; n++) begin
      step;
      if (n == 1) begin
        total++; if (exit_done_o !== 1'b1) $display("FAIL rr_recapture got %b want 1", exit_done_o); else pass_cnt++;
      end
      p = exp_pat(n - 1, 3, 1);
      e = {2'b00, n <= 20 ? 1'b0 : n <= 30 ? 1'b1 : p, p};
      total++; if (led_o !== e) $display("FAIL rr_led n=%0d got %h want %h", n, led_o, e); else pass_cnt++;
      if (n == 20) mode_i = 8'h07;
      if (n == 30) mode_i = 8'h0F;
    end
  endtask
  initial begin
    test_reset;
    test_heartbeat;
    test_exit_pass;
    test_burst(32'd3, 3, 100);
    test_burst(32'h10, 16, 300);
    test_capture_on_tick;
    test_reset_restart;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
